// File: rtl/tank_pkg.sv
// Shared types and key-map constants for the tank fire arbiter.
package tank_pkg;
  localparam int N_TANK = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int KEY_UP_OFS    = 0;
  localparam int KEY_DOWN_OFS  = 1;
  localparam int KEY_LEFT_OFS  = 2;
  localparam int KEY_RIGHT_OFS = 3;
  localparam int KEY_FIRE_BASE = 16;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  // Direction key nibble -> facing, up > down > left > right.
  function automatic dir_t dir_pick(input logic [3:0] k);
    if (k[KEY_UP_OFS])        return DIR_UP;
    else if (k[KEY_DOWN_OFS]) return DIR_DOWN;
    else if (k[KEY_LEFT_OFS]) return DIR_LEFT;
    else                      return DIR_RIGHT;
  endfunction
endpackage

// File: rtl/tank_fire_arbiter_if.sv
// Valid/ready bullet-spawn port between the arbiter (master) and bullet engine (slave).
interface tank_fire_arbiter_if;
  import tank_pkg::*;
  logic       fire_valid;
  logic       fire_ready;
  logic [1:0] fire_tank;
  dir_t       fire_dir;

  modport master (output fire_valid, fire_tank, fire_dir, input fire_ready);
  modport slave  (input fire_valid, fire_tank, fire_dir, output fire_ready);
endinterface

// File: rtl/tank_fire_arbiter_cooldown.sv
// Per-tank shot cooldown: loads COOLDOWN on an accepted shot, counts down, saturates at 0.
module fire_cooldown #(
  parameter int COOLDOWN = 25_000_000,
  parameter int CD_W     = $clog2(COOLDOWN + 1)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load_i,
  output logic zero_o
);
  logic [CD_W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)              cnt_q <= '0;
    else if (load_i)         cnt_q <= CD_W'(COOLDOWN);
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/tank_fire_arbiter.sv
// Tank fire arbiter: facing tracking, fire capture, round-robin spawn grant, per-tank cooldown.
// Define FIRE_AUTOREPEAT_EN to make fire level-sensitive (held fire repeats each cooldown).
module tank_fire_arbiter
  import tank_pkg::*;
#(
  parameter int COOLDOWN = 25_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [19:0]          keys_in,
  tank_fire_arbiter_if.master  fire,
  output logic [7:0]           facing_out,
  output logic [3:0]           cooling_out
);
  localparam int CD_W = $clog2(COOLDOWN + 1);

  logic [N_TANK-1:0][1:0] facing_q;
  logic [N_TANK-1:0]      fire_prev_q, pending_q, pending_d;
  logic [N_TANK-1:0]      fire_req, cd_zero, cd_load;
  logic [N_TANK-1:0]      fire_lvl;
  state_t                 state_q;
  logic [1:0]             last_grant_q, tank_q, grant;
  dir_t                   dir_q;
  logic                   valid_q, found, hs;

  assign fire_lvl = keys_in[KEY_FIRE_BASE +: N_TANK];
  assign hs       = (state_q == S_OFFER) && fire.fire_ready;

  for (genvar i = 0; i < N_TANK; i++) begin : g_tank
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                    facing_q[i] <= DIR_UP;
      else if (|keys_in[4*i +: 4])   facing_q[i] <= dir_pick(keys_in[4*i +: 4]);
    end

    assign cd_load[i] = hs && (tank_q == 2'(i));

    fire_cooldown #(.COOLDOWN(COOLDOWN), .CD_W(CD_W)) u_cd (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .load_i (cd_load[i]),
      .zero_o (cd_zero[i])
    );
  end

`ifdef FIRE_AUTOREPEAT_EN
  assign fire_req = fire_lvl;
`else
  assign fire_req = fire_lvl & ~fire_prev_q;
`endif

  // The handshaken tank still has pending set this cycle, so its own edge is dropped.
  assign pending_d = (pending_q & ~cd_load) | (fire_req & cd_zero & ~pending_q);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fire_prev_q <= '0;
      pending_q   <= '0;
    end else begin
      fire_prev_q <= fire_lvl;
      pending_q   <= pending_d;
    end
  end

  always_comb begin
    found = 1'b0;
    grant = last_grant_q;
    for (int k = 1; k <= N_TANK; k++) begin
      if (!found && pending_q[last_grant_q + 2'(k)]) begin
        found = 1'b1;
        grant = last_grant_q + 2'(k);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      tank_q       <= '0;
      dir_q        <= DIR_UP;
      last_grant_q <= 2'd3;
    end else begin
      case (state_q)
        S_IDLE: if (found) begin
          tank_q  <= grant;
          dir_q   <= dir_t'(facing_q[grant]);
          valid_q <= 1'b1;
          state_q <= S_OFFER;
        end
        S_OFFER: if (fire.fire_ready) begin
          valid_q      <= 1'b0;
          last_grant_q <= tank_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fire.fire_valid = valid_q;
  assign fire.fire_tank  = tank_q;
  assign fire.fire_dir   = dir_q;
  assign facing_out      = facing_q;
  assign cooling_out     = ~cd_zero;
endmodule
